// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
// Pure declarations; no logic, no latency.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_NUM_OUT     = 4;
  localparam int DEF_GAP_CYCLES  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Saturating up-counter with clear/load/enable and a compare against tc_val_i.
// Count updates one cycle after enable; tc_o is a compare on the registered count.
module seq_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear beats load beats increment; saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/reset_seq.sv
// Power-on / software reset sequencer: hold all outputs low, then release them one by one.
// All outputs are flops; a release lands on the edge the hold/gap count expires.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int NUM_OUT     = DEF_NUM_OUT,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_OUT + 1);

  state_e             state_q, state_d;
  logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]   tc_val;

  assign tc_val = (state_q == HOLD) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1);

  seq_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_val_i   (tc_val),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    rst_n_d = rst_n_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      HOLD: begin
        if (sw_rst_req) begin
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          rst_n_d = NUM_OUT'(1);
          idx_d   = IDX_W'(1);
          cnt_clr = 1'b1;
          if (NUM_OUT == 1) begin
            state_d = RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = STAGE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      STAGE: begin
        if (sw_rst_req) begin
          state_d = HOLD;
          rst_n_d = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          // idx_q is the next bit to release, so the output stays a thermometer code.
          rst_n_d = rst_n_q | (NUM_OUT'(1) << idx_q);
          idx_d   = idx_q + IDX_W'(1);
          cnt_clr = 1'b1;
          if (idx_q == IDX_W'(NUM_OUT - 1)) begin
            state_d = RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      RUN: begin
        if (sw_rst_req) begin
          state_d = HOLD;
          rst_n_d = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        rst_n_d = '0;
        idx_d   = '0;
        busy_d  = 1'b1;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      rst_n_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_n_q <= rst_n_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_out = rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: minimum cycles all outputs stay in reset; legal range 2..1024.
REQ-002 Parameter NUM_OUT, default 4: number of sequenced reset outputs; legal range 1..8.
REQ-003 Parameter GAP_CYCLES, default 4: cycles between consecutive output releases; legal range 1..1024.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sw_rst_req  input  1  level-sampled software reset request, active-high.
REQ-007 rst_n_out  output  NUM_OUT  active-low resets to downstream blocks, registered.
REQ-008 busy  output  1  high while any rst_n_out bit is low.
REQ-009 done  output  1  single-cycle pulse when the sequence completes.

Function
REQ-010 The FSM SHALL have three states: HOLD, STAGE and RUN.
REQ-011 Edge 1 is the first posedge sampling reset=0. In HOLD, the counter SHALL increment each edge; on edge HOLD_CYCLES the FSM SHALL set rst_n_out[0]=1, clear the counter and enter STAGE.
REQ-012 In STAGE, every GAP_CYCLES edges the FSM SHALL release the next output in ascending order (bit 1, then bit 2, and so on).
REQ-013 rst_n_out SHALL always be a thermometer code: bit i is high only if bits 0..i-1 are high.
REQ-014 On the edge that releases bit NUM_OUT-1, the FSM SHALL enter RUN and assert done for exactly one cycle.
REQ-015 If NUM_OUT=1, the FSM SHALL go from HOLD directly to RUN on edge HOLD_CYCLES, and done SHALL pulse on that edge.
REQ-016 busy SHALL be high in HOLD and STAGE and low in RUN, registered in step with rst_n_out.
REQ-017 In RUN, sw_rst_req=1 at an edge SHALL drive all rst_n_out low, clear the counter, set busy and enter HOLD on that edge.
REQ-018 In STAGE, sw_rst_req=1 SHALL abort the sequence: all outputs low, counter cleared, FSM returns to HOLD.
REQ-019 In HOLD, sw_rst_req=1 SHALL clear the counter, so the hold window restarts. A held-high request SHALL keep the block in HOLD indefinitely.
REQ-020 The counter SHALL be $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits wide and SHALL never wrap; it is cleared on every state change and on every release.
REQ-021 reset SHALL take priority over sw_rst_req.

Reset
REQ-022 reset=1 at an edge SHALL force state HOLD, counter 0, rst_n_out all 0, busy 1, done 0 and stage index 0.
REQ-023 reset asserted mid-sequence or in RUN SHALL apply REQ-022 on that same edge.
REQ-024 The full sequence SHALL restart from edge 1 after reset deasserts.

Structure
REQ-025 Package reset_seq_pkg SHALL hold the state enum (HOLD, STAGE, RUN) and the default parameter constants.
REQ-026 One sub-module, seq_counter, SHALL be used: a loadable up-counter with clear, enable and terminal-count compare.
REQ-027 All outputs SHALL be driven directly from flops; no combinational path from input to output.

Verification (defaults HOLD=16, NUM_OUT=4, GAP=4)
REQ-028 Release reset:
  - rst_n_out=0000 through edge 15.
  - 0001 at edge 16, 0011 at 20, 0111 at 24, 1111 at 28.
  - done high for the single cycle after edge 28; busy falls at edge 28.
REQ-029 In RUN, pulse sw_rst_req for 1 cycle at edge T:
  - rst_n_out=0000 and busy=1 at edge T.
  - 0001 at T+16, 1111 at T+28, done pulse after T+28.
REQ-030 Pulse sw_rst_req at edge 22 (state 0011):
  - outputs 0000 at edge 22.
  - 0001 at edge 38, 1111 at edge 50.
  - only one done pulse, after edge 50.
REQ-031 Hold sw_rst_req high from edge 10 to edge 40:
  - rst_n_out stays 0000 throughout.
  - 0001 at edge 56.
REQ-032 Assert reset at edge 26 (state 0111) together with sw_rst_req:
  - outputs 0000, busy 1, done 0 immediately.
  - the sequence restarts from edge 1 after reset deasserts.
REQ-033 Run the parameter sweeps below and check the thermometer invariant with an assertion on every cycle of every test:
  - NUM_OUT=1, HOLD=2: rst_n_out rises and done pulses at edge 2.
  - GAP=1: consecutive bits release on consecutive edges.
